// File: rtl/nes_vga_scan_doubler.sv
// Line-doubling scan converter: NES 256x240 pixels into a two-line ping-pong
// buffer, replayed 2x2 on a 640x480 VGA raster that is frame-locked to the NES.
module nes_vga_scan_doubler #(
  parameter int         PIX_DIV     = 4,
  parameter int         H_TOTAL     = 800,
  parameter int         V_TOTAL     = 520,
  parameter int         H_PIC_START = 64,
  parameter logic [7:0] BORDER_RGB  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] i_nes_x,
  input  logic [9:0] i_nes_y,
  input  logic       i_pix_pulse,
  input  logic [2:0] i_r,
  input  logic [2:0] i_g,
  input  logic [1:0] i_b,
  output logic       o_vga_hsync,
  output logic       o_vga_vsync,
  output logic [2:0] o_vga_r,
  output logic [2:0] o_vga_g,
  output logic [1:0] o_vga_b,
  output logic       o_de,
  output logic       o_locked,
  output logic       o_resync
);

  localparam int              DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [9:0]      H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]      V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]      H_ACTIVE = 10'd640;
  localparam logic [9:0]      V_ACTIVE = 10'd480;
  localparam logic [9:0]      H_PIC_LO = 10'(H_PIC_START);
  localparam logic [9:0]      H_PIC_HI = 10'(H_PIC_START + 511);
  localparam logic [9:0]      HS_LO    = 10'd656;
  localparam logic [9:0]      HS_HI    = 10'd751;
  localparam logic [9:0]      VS_LO    = 10'd490;
  localparam logic [9:0]      VS_HI    = 10'd491;

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t        state;
  logic [9:0]    h;
  logic [9:0]    v;
  logic [DW-1:0] div;

  // i_pix_pulse is a one-cycle strobe with no back-pressure: x/y/rgb are valid
  // only in that cycle and every strobe is consumed.
  logic wr_en;
  logic lock_ev;
  logic tick;
  logic at_frame_end;

  assign wr_en        = i_pix_pulse && (i_nes_x < 10'd256) && (i_nes_y < 10'd240);
  assign lock_ev      = i_pix_pulse && (i_nes_x == 10'd0) && (i_nes_y == 10'd1);
  assign tick         = (state == LOCKED) && (div == DIV_LAST);
  assign at_frame_end = (h == H_LAST) && (v == V_LAST) && (div == DIV_LAST);

  // Stage 0: decode the current raster position and form the read address.
  logic       s0_active;
  logic       s0_pic;
  logic       s0_hs;
  logic       s0_vs;
  logic [8:0] rd_addr;

  always_comb begin
    s0_active = (h < H_ACTIVE) && (v < V_ACTIVE);
    s0_pic    = s0_active && (h >= H_PIC_LO) && (h <= H_PIC_HI);
    s0_hs     = !((h >= HS_LO) && (h <= HS_HI));
    s0_vs     = !((v >= VS_LO) && (v <= VS_HI));
    // Bank is row[0] = v[1]; column halves the VGA offset into the picture.
    rd_addr   = {v[1], 8'((h - H_PIC_LO) >> 1)};
  end

  logic [7:0] line_buf [0:511];
  logic [7:0] rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) line_buf[{i_nes_y[0], i_nes_x[7:0]}] <= {i_r, i_g, i_b};
    if (tick)  rd_data <= line_buf[rd_addr];
  end

  // Stage 1 flags travel alongside rd_data.
  logic s1_active;
  logic s1_pic;
  logic s1_hs;
  logic s1_vs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= UNLOCKED;
      h           <= '0;
      v           <= '0;
      div         <= '0;
      s1_active   <= 1'b0;
      s1_pic      <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      o_vga_hsync <= 1'b1;
      o_vga_vsync <= 1'b1;
      o_vga_r     <= '0;
      o_vga_g     <= '0;
      o_vga_b     <= '0;
      o_de        <= 1'b0;
      o_locked    <= 1'b0;
      o_resync    <= 1'b0;
    end else begin
      case (state)
        UNLOCKED: begin
          o_resync <= 1'b0;
          if (lock_ev) begin
            state    <= LOCKED;
            o_locked <= 1'b1;
          end
        end
        LOCKED: begin
          o_resync <= lock_ev && !at_frame_end;
          if (lock_ev) begin
            h   <= '0;
            v   <= '0;
            div <= '0;
          end else if (div == DIV_LAST) begin
            div <= '0;
            if (h == H_LAST) begin
              h <= '0;
              v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
              h <= h + 10'd1;
            end
          end else begin
            div <= div + DW'(1);
          end
          if (tick) begin
            s1_active   <= s0_active;
            s1_pic      <= s0_pic;
            s1_hs       <= s0_hs;
            s1_vs       <= s0_vs;
            o_vga_hsync <= s1_hs;
            o_vga_vsync <= s1_vs;
            o_de        <= s1_active;
            {o_vga_r, o_vga_g, o_vga_b} <= s1_pic ? rd_data
                                         : (s1_active ? BORDER_RGB : 8'h00);
          end
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_vga_scan_doubler.sv
// Randomized bench for nes_vga_scan_doubler: a pixel-level raster model feeds an
// expected queue that a negedge monitor drains as the DUT advances each VGA pixel.
module tb_nes_vga_scan_doubler;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] nes_x;
  logic [9:0] nes_y;
  logic       pix_pulse;
  logic [7:0] rgb_in;
  logic       vga_hsync, vga_vsync, de, locked, resync;
  logic [2:0] vga_r, vga_g;
  logic [1:0] vga_b;

  always #5 clk = ~clk;

  nes_vga_scan_doubler dut (
    .clk         (clk),
    .rst         (rst),
    .i_nes_x     (nes_x),
    .i_nes_y     (nes_y),
    .i_pix_pulse (pix_pulse),
    .i_r         (rgb_in[7:5]),
    .i_g         (rgb_in[4:2]),
    .i_b         (rgb_in[1:0]),
    .o_vga_hsync (vga_hsync),
    .o_vga_vsync (vga_vsync),
    .o_vga_r     (vga_r),
    .o_vga_g     (vga_g),
    .o_vga_b     (vga_b),
    .o_de        (de),
    .o_locked    (locked),
    .o_resync    (resync)
  );

  // {hsync, vsync, de, rgb}
  localparam logic [10:0] IDLE = {1'b1, 1'b1, 1'b0, 8'h00};

  logic [10:0] exp_q[$];
  logic [10:0] cur_exp = IDLE;
  logic [7:0]  model_buf [2][256];
  int          cyc = 0;
  int          base_cyc = 0;
  bit          model_locked = 1'b0;
  bit          exp_resync = 1'b0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [10:0] ref_pixel(input int h, input int v);
    bit         active;
    bit         pic;
    logic [7:0] rgb;
    active = (h < 640) && (v < 480);
    pic    = active && (h >= 64) && (h < 576);
    rgb    = pic ? model_buf[(v / 2) % 2][(h - 64) / 2] : 8'h00;
    return {!(h >= 656 && h <= 751), !(v == 490 || v == 491), active, rgb};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, want);
    end
  endtask

  // Reference model: evaluates what the DUT saw at each rising edge.
  always @(posedge clk) begin : model
    int el;
    int k;
    #1;
    cyc++;
    el = cyc - base_cyc;
    k  = el / 4;
    exp_resync = 1'b0;
    if (!rst) begin
      model_locked = 1'b0;
      exp_q.delete();
    end else begin
      if (model_locked && (el % 4 == 3))
        exp_q.push_back(ref_pixel(k % 800, (k / 800) % 520));
      if (pix_pulse && nes_x < 256 && nes_y < 240)
        model_buf[nes_y[0]][nes_x[7:0]] = rgb_in;
      if (pix_pulse && nes_x == 0 && nes_y == 1) begin
        if (model_locked)
          exp_resync = !((el % 4 == 3) && (k % 800 == 799) && ((k / 800) % 520 == 519));
        else begin
          exp_q.delete();
          exp_q.push_back(IDLE);
        end
        model_locked = 1'b1;
        base_cyc     = cyc + 1;
      end
    end
  end

  // Monitor: a new expected entry beyond the one in flight means the DUT just
  // advanced a VGA pixel and presented the older one.
  always @(negedge clk) begin
    if (!model_locked) cur_exp = IDLE;
    else if (exp_q.size() > 1) cur_exp = exp_q.pop_front();
    check("video", {21'd0, vga_hsync, vga_vsync, de, vga_r, vga_g, vga_b}, {21'd0, cur_exp});
    check("locked", {31'd0, locked}, {31'd0, model_locked});
    check("resync", {31'd0, resync}, {31'd0, exp_resync});
  end

  task automatic drive_pix(input int x, input int y, input logic [7:0] d);
    @(negedge clk);
    pix_pulse = 1'b1;
    nes_x     = 10'(x);
    nes_y     = 10'(y);
    rgb_in    = d;
    @(negedge clk);
    pix_pulse = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic write_row(input int y, input int x_first);
    logic [7:0] d;
    for (int x = x_first; x < 256; x++) begin
      d = 8'($urandom);
      if (y == 0 && x == 0)   d = 8'hE0;
      if (y == 0 && x == 255) d = 8'h03;
      if (y == 5 && x == 10)  d = 8'h1C;
      drive_pix(x, y, d);
    end
  endtask

  initial begin : stim
    int lock_c;
    rst       = 1'b0;
    pix_pulse = 1'b0;
    nes_x     = '0;
    nes_y     = '0;
    rgb_in    = '0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    repeat (20) @(negedge clk);

    // Fill both banks, then lock; row 1 x=0 is the lock pulse itself.
    write_row(0, 0);
    write_row(1, 1);
    drive_pix(0, 1, 8'($urandom));
    lock_c = cyc;

    // While line pair 2k,2k+1 shows row k, refill the other bank with row k+1.
    for (int k = 0; k < 6; k++) begin
      wait_cyc(lock_c + 1 + 2 * k * 3200 + 8);
      write_row(k + 1, (k == 0) ? 1 : 0);
      if (k == 2) begin
        drive_pix(300, 0, 8'hFF);
        drive_pix(5, 245, 8'hFF);
        drive_pix(44, 999, 8'hAA);
      end
    end
    wait_cyc(lock_c + 1 + 13 * 3200 + 16);

    // Mid-frame reset, idle without a lock event, relock, then force a resync.
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    repeat (40) @(negedge clk);
    drive_pix(0, 1, 8'($urandom));
    repeat ((3 * 800 + 100) * 4) @(negedge clk);
    drive_pix(0, 1, 8'($urandom));
    repeat (3400) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nes_vga_scan_doubler.md
Name: nes_vga_scan_doubler

Overview:
- Downstream of the NES RGB/VGA timing generator.
- Captures each 256x240 NES pixel (3-3-2 RGB) on the generator's pixel pulse into a two-line ping-pong buffer.
- Re-emits the picture on a 640x480-active VGA raster: 2x horizontal, 2x vertical, 64-pixel black side borders.
- Output raster is frame-locked to the NES frame, so no frame buffer is needed.

Parameters:
- PIX_DIV, 4: system clocks per VGA pixel (100 MHz / 4 = 25 MHz).
- H_TOTAL, 800: VGA clocks per line.
- V_TOTAL, 520: VGA lines per frame (480 active, 10 FP, 2 sync, 28 BP).
- H_PIC_START, 64: first VGA column of the doubled picture.
- BORDER_RGB, 8'h00: colour outside the picture but inside the active area.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- i_nes_x  input  10  NES x coordinate from the timing generator.
- i_nes_y  input  10  NES y coordinate from the timing generator.
- i_pix_pulse  input  1  one-clk strobe; x/y/RGB valid this cycle.
- i_r  input  3  NES pixel red.
- i_g  input  3  NES pixel green.
- i_b  input  2  NES pixel blue.
- o_vga_hsync  output  1  active-low horizontal sync.
- o_vga_vsync  output  1  active-low vertical sync.
- o_vga_r  output  3  VGA red.
- o_vga_g  output  3  VGA green.
- o_vga_b  output  2  VGA blue.
- o_de  output  1  active-video enable.
- o_locked  output  1  raster locked to the NES frame.
- o_resync  output  1  one-clk pulse when a lock event found the counters misaligned.

Behaviour:
- Reset (rst=0, async) outputs: hsync=1, vsync=1, rgb=0, de=0, locked=0, resync=0.
- Reset internal state: state=UNLOCKED, h=v=div=0, delay pipeline cleared. Buffer contents are don't-care.
- Write side, every cycle regardless of state:
  - Condition: i_pix_pulse && i_nes_x<256 && i_nes_y<240.
  - Action: buf[bank=i_nes_y[0]][i_nes_x[7:0]] <= {i_r,i_g,i_b}.
  - Out-of-range coordinates are discarded.
- Lock event: i_pix_pulse && i_nes_x==0 && i_nes_y==1.
- State machine:
  - UNLOCKED: counters held at 0; outputs held at reset values. On a lock event: next cycle state=LOCKED, h=v=div=0, o_locked=1.
  - LOCKED: div counts 0..PIX_DIV-1. At div==PIX_DIV-1, h advances. h wraps at H_TOTAL-1 and increments v; v wraps at V_TOTAL-1.
  - LOCKED lock event: counters are forced to 0 next cycle. If they were not at (h=H_TOTAL-1, v=V_TOTAL-1, div=PIX_DIV-1) on the event cycle, o_resync pulses for one clk. Steady state gives no pulse, since 800*520*4 = 400*260*16 clks.
- Pipeline, each stage advancing on div==PIX_DIV-1:
  - Stage 0: from (h,v) compute active=(h<640 && v<480), pic=active && h in [64,575], addr=(h-64)>>1 (8 bits), row=v>>1, rd_bank=row[0]. Issue the synchronous buffer read.
  - Stage 1: hold read data and delayed flags.
  - Stage 2: register outputs: rgb = pic ? data : (active ? BORDER_RGB : 0); de=active.
  - Sync decode: hsync=!(h in [656,751]); vsync=!(v in [490,491]).
- Latency: all outputs lag their (h,v) by exactly 2 VGA pixels (8 clks), and syncs/de/rgb stay mutually aligned.
- Bank safety: VGA line pair 2n,2n+1 reads NES row n from bank n[0] while the generator writes row n+1 into bank !n[0]. A simultaneous read/write never targets the same bank.
- Losing pulses (no lock event) leaves the block free-running in LOCKED. Only reset returns it to UNLOCKED.

Test Plan:
- Reset: drive rst=0 mid-frame -> next cycle hsync=vsync=1, rgb=0, de=0, locked=0. Release rst with no lock event -> outputs stay at reset values.
- Lock: present a lock event at cycle T -> o_locked=1 at T+1. First o_de=1 at T+1+8; first hsync low at T+1+(656+2)*4.
- Pixel mapping: write NES row 0 with x=0 -> 8'hE0 and x=255 -> 8'h03.
  - VGA line 0 cols 0..63 -> 0 with de=1.
  - Cols 64,65 -> E0; cols 574,575 -> 03; cols 576..639 -> 0.
- Vertical doubling: write row 5 x=10 -> 8'h1C -> VGA lines 10 and 11 show 1C at cols 84 and 85; line 12 shows row 6 data.
- Resync: while locked, inject an extra lock event at h=100,v=3 -> one o_resync pulse and counters restart at 0. The next natural event produces no pulse.
- Write filter: pulses with x=300 or y=245 -> buffer contents unchanged and displayed pixels unaffected.
